// File: rtl/data_mem_hs.sv
// Byte-addressable data memory with valid/ready request and response channels.
// Supports byte/half/word loads and stores, a programmable access latency and access-error flagging.
module data_mem_hs #(
    parameter int    DEPTH_BYTES = 1024,
    parameter int    ADDR_W      = 32,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [7:0] mem [DEPTH_BYTES];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // With zero latency the access happens on the accept edge itself, so the
    // access fields come straight from the request port while IDLE.
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_size;
    logic              acc_uns;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic              access;
    logic              mem_we;
    logic [2:0]        span;
    logic [ADDR_W:0]   last_addr;
    logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       load_val;

    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_wdata = wdata_q;
        end
    end

    // Range check runs one bit wider than the address so the end never wraps.
    always_comb begin
        case (acc_size)
            2'b00:   span = 3'd0;
            2'b01:   span = 3'd1;
            default: span = 3'd3;
        endcase
        last_addr = {1'b0, acc_addr} + {{(ADDR_W-2){1'b0}}, span};
        acc_err   = (acc_size == 2'b11)
                 || (acc_size == 2'b01 && acc_addr[0])
                 || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
                 || (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));
    end

    always_comb begin
        idx0 = acc_addr[IDX_W-1:0];
        idx1 = idx0 + IDX_W'(1);
        idx2 = idx0 + IDX_W'(2);
        idx3 = idx0 + IDX_W'(3);
        b0   = mem[idx0];
        b1   = mem[idx1];
        b2   = mem[idx2];
        b3   = mem[idx3];
        case (acc_size)
            2'b00:   load_val = {{24{~acc_uns & b0[7]}}, b0};
            2'b01:   load_val = {{16{~acc_uns & b1[7]}}, b1, b0};
            default: load_val = {b3, b2, b1, b0};
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        access      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        cnt_d   = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : load_val;
        end

        req_ready_d = (state_d == IDLE);
        mem_we      = access && acc_we && !acc_err;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the storage array has no reset; a committed store survives rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx0] <= acc_wdata[7:0];
            if (acc_size != 2'b00) begin
                mem[idx1] <= acc_wdata[15:8];
            end
            if (acc_size == 2'b10) begin
                mem[idx2] <= acc_wdata[23:16];
                mem[idx3] <= acc_wdata[31:24];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
